// File: rtl/bcd_countdown_timer_pkg.sv
// Shared widths, BCD constants and controller state encodings for the MM:SS countdown timer.
package bcd_countdown_timer_pkg;

    localparam int BCD_BIT_WIDTH = 4;

    typedef logic [BCD_BIT_WIDTH-1:0] bcd_t;

    localparam bcd_t BCD_ZERO  = 4'd0;
    localparam bcd_t BCD_ONE   = 4'd1;
    localparam bcd_t BCD_FIVE  = 4'd5;
    localparam bcd_t BCD_NINE  = 4'd9;
    localparam bcd_t DECREMENT = 4'd1;

    localparam logic ENABLED  = 1'b1;
    localparam logic DISABLED = 1'b0;

    typedef enum logic [1:0] {
        STATE_IDLE    = 2'b00,
        STATE_RUN     = 2'b01,
        STATE_PAUSE   = 2'b10,
        STATE_EXPIRED = 2'b11
    } state_e;

    function automatic logic is_zero_time(bcd_t mt, bcd_t mu, bcd_t st, bcd_t su);
        return (mt == BCD_ZERO) && (mu == BCD_ZERO) && (st == BCD_ZERO) && (su == BCD_ZERO);
    endfunction

    // True at 00:01, the only value from which a single decrement reaches 00:00.
    function automatic logic is_last_second(bcd_t mt, bcd_t mu, bcd_t st, bcd_t su);
        return (mt == BCD_ZERO) && (mu == BCD_ZERO) && (st == BCD_ZERO) && (su == BCD_ONE);
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_dcounter.sv
// One BCD down-counting digit: wraps from zero to its limit and raises borrow while doing so.
module bcd_countdown_timer_dcounter
    import bcd_countdown_timer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     decrease,
    input  logic                     load_default,
    input  logic [BCD_BIT_WIDTH-1:0] def_value,
    input  logic [BCD_BIT_WIDTH-1:0] limit,
    output logic [BCD_BIT_WIDTH-1:0] value,
    output logic                     borrow
);

    logic [BCD_BIT_WIDTH-1:0] value_q;
    logic [BCD_BIT_WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load_default) begin
            value_d = def_value;
        end else if (decrease) begin
            // Out-of-range loads simply step down by one until they reach zero.
            if (value_q == BCD_ZERO) begin
                value_d = limit;
            end else begin
                value_d = value_q - DECREMENT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= BCD_ZERO;
        end else begin
            value_q <= value_d;
        end
    end

    assign value  = value_q;
    assign borrow = decrease && (value_q == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS countdown timer: four cascaded BCD down digits plus the IDLE/RUN/PAUSE/EXPIRED controller.
//   state         | meaning
//   STATE_IDLE    | loaded or reset, waiting for start
//   STATE_RUN     | digits decrement on every tick
//   STATE_PAUSE   | frozen mid-count, start resumes
//   STATE_EXPIRED | reached 00:00, only load or reset leaves
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick,
    input  logic                     start,
    input  logic                     pause,
    input  logic                     load,
    input  logic [BCD_BIT_WIDTH-1:0] preset_min_t,
    input  logic [BCD_BIT_WIDTH-1:0] preset_min_u,
    input  logic [BCD_BIT_WIDTH-1:0] preset_sec_t,
    input  logic [BCD_BIT_WIDTH-1:0] preset_sec_u,
    output logic [BCD_BIT_WIDTH-1:0] min_t,
    output logic [BCD_BIT_WIDTH-1:0] min_u,
    output logic [BCD_BIT_WIDTH-1:0] sec_t,
    output logic [BCD_BIT_WIDTH-1:0] sec_u,
    output logic                     running,
    output logic                     expired
);

    state_e state_q;
    logic   running_q;
    logic   expired_q;

    logic dec_en;
    logic su_borrow;
    logic st_borrow;
    logic mu_borrow;
    logic mt_borrow;
    logic value_nonzero;
    logic reach_zero;

    // load and pause both outrank tick, so either one suppresses the decrement.
    assign dec_en        = tick && (state_q == STATE_RUN) && !load && !pause;
    assign value_nonzero = !is_zero_time(min_t, min_u, sec_t, sec_u);
    assign reach_zero    = dec_en && (is_last_second(min_t, min_u, sec_t, sec_u) || mt_borrow);

    bcd_countdown_timer_dcounter u_sec_u (
        .clk          (clk),
        .rst_n        (rst_n),
        .decrease     (dec_en),
        .load_default (load),
        .def_value    (preset_sec_u),
        .limit        (BCD_NINE),
        .value        (sec_u),
        .borrow       (su_borrow)
    );

    bcd_countdown_timer_dcounter u_sec_t (
        .clk          (clk),
        .rst_n        (rst_n),
        .decrease     (su_borrow),
        .load_default (load),
        .def_value    (preset_sec_t),
        .limit        (BCD_FIVE),
        .value        (sec_t),
        .borrow       (st_borrow)
    );

    bcd_countdown_timer_dcounter u_min_u (
        .clk          (clk),
        .rst_n        (rst_n),
        .decrease     (st_borrow),
        .load_default (load),
        .def_value    (preset_min_u),
        .limit        (BCD_NINE),
        .value        (min_u),
        .borrow       (mu_borrow)
    );

    bcd_countdown_timer_dcounter u_min_t (
        .clk          (clk),
        .rst_n        (rst_n),
        .decrease     (mu_borrow),
        .load_default (load),
        .def_value    (preset_min_t),
        .limit        (BCD_NINE),
        .value        (min_t),
        .borrow       (mt_borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= STATE_IDLE;
            running_q <= DISABLED;
            expired_q <= DISABLED;
        end else if (load) begin
            state_q   <= STATE_IDLE;
            running_q <= DISABLED;
            expired_q <= DISABLED;
        end else begin
            case (state_q)
                STATE_IDLE, STATE_PAUSE: begin
                    if (!pause && start && value_nonzero) begin
                        state_q   <= STATE_RUN;
                        running_q <= ENABLED;
                    end
                end
                STATE_RUN: begin
                    if (pause) begin
                        state_q   <= STATE_PAUSE;
                        running_q <= DISABLED;
                    end else if (reach_zero) begin
                        state_q   <= STATE_EXPIRED;
                        running_q <= DISABLED;
                        expired_q <= ENABLED;
                    end
                end
                STATE_EXPIRED: begin
                    state_q <= STATE_EXPIRED;
                end
                default: begin
                    state_q   <= STATE_IDLE;
                    running_q <= DISABLED;
                    expired_q <= DISABLED;
                end
            endcase
        end
    end

    assign running = running_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for the MM:SS countdown timer: vector table plus multi-cycle corner sequences.
module tb_bcd_countdown_timer;

    logic       clk;
    logic       rst_n;
    logic       tick, start, pause, load;
    logic [3:0] preset_min_t, preset_min_u, preset_sec_t, preset_sec_u;
    logic [3:0] min_t, min_u, sec_t, sec_u;
    logic       running, expired;

    int checks;
    int errors;

    typedef struct {
        string      name;
        logic       ld;
        logic       pa;
        logic       st;
        logic       tk;
        logic [15:0] pre;
        logic [15:0] exp_val;
        logic       exp_run;
        logic       exp_exp;
    } vec_t;

    vec_t vecs[$];

    bcd_countdown_timer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .start        (start),
        .pause        (pause),
        .load         (load),
        .preset_min_t (preset_min_t),
        .preset_min_u (preset_min_u),
        .preset_sec_t (preset_sec_t),
        .preset_sec_u (preset_sec_u),
        .min_t        (min_t),
        .min_u        (min_u),
        .sec_t        (sec_t),
        .sec_u        (sec_u),
        .running      (running),
        .expired      (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic ld, logic pa, logic st, logic tk,
                                logic [15:0] pre, logic [15:0] ev, logic er, logic ee);
        vec_t v;
        v.name = name; v.ld = ld; v.pa = pa; v.st = st; v.tk = tk;
        v.pre = pre; v.exp_val = ev; v.exp_run = er; v.exp_exp = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] ev, input logic er, input logic ee);
        logic [15:0] got;
        got = {min_t, min_u, sec_t, sec_u};
        checks++;
        if (got !== ev || running !== er || expired !== ee || (running && expired)) begin
            errors++;
            $display("FAIL %s: got %h run=%b exp=%b, required %h run=%b exp=%b",
                     name, got, running, expired, ev, er, ee);
        end
    endtask

    task automatic step(input logic ld, input logic pa, input logic st, input logic tk,
                        input logic [15:0] pre);
        @(negedge clk);
        load = ld; pause = pa; start = st; tick = tk;
        {preset_min_t, preset_min_u, preset_sec_t, preset_sec_u} = pre;
        @(posedge clk);
        #1;
        load = 1'b0; pause = 1'b0; start = 1'b0; tick = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        tick = 1'b0; start = 1'b0; pause = 1'b0; load = 1'b0;
        {preset_min_t, preset_min_u, preset_sec_t, preset_sec_u} = 16'h0000;

        //          name          ld pa st tk  preset     expect   run exp
        vecs.push_back(mk("load_0003",   1, 0, 0, 0, 16'h0003, 16'h0003, 0, 0));
        vecs.push_back(mk("start_0003",  0, 0, 1, 0, 16'h0000, 16'h0003, 1, 0));
        vecs.push_back(mk("tick_0002",   0, 0, 0, 1, 16'h0000, 16'h0002, 1, 0));
        vecs.push_back(mk("tick_0001",   0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0));
        vecs.push_back(mk("tick_expire", 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1));
        vecs.push_back(mk("exp_start",   0, 0, 1, 1, 16'h0000, 16'h0000, 0, 1));
        vecs.push_back(mk("exp_pause",   0, 1, 0, 1, 16'h0000, 16'h0000, 0, 1));
        vecs.push_back(mk("load_0005",   1, 0, 0, 0, 16'h0005, 16'h0005, 0, 0));
        vecs.push_back(mk("idle_tick",   0, 0, 0, 1, 16'h0000, 16'h0005, 0, 0));
        vecs.push_back(mk("load_0000",   1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk("zero_start",  0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk("load_0070",   1, 0, 0, 0, 16'h0070, 16'h0070, 0, 0));
        vecs.push_back(mk("start_0070",  0, 0, 1, 0, 16'h0000, 16'h0070, 1, 0));
        vecs.push_back(mk("oor_0069",    0, 0, 0, 1, 16'h0000, 16'h0069, 1, 0));
        vecs.push_back(mk("run_st_tick", 0, 0, 1, 1, 16'h0000, 16'h0068, 1, 0));
        vecs.push_back(mk("load_0A00",   1, 0, 0, 0, 16'h0A00, 16'h0A00, 0, 0));
        vecs.push_back(mk("start_0A00",  0, 0, 1, 0, 16'h0000, 16'h0A00, 1, 0));
        vecs.push_back(mk("oor_0959",    0, 0, 0, 1, 16'h0000, 16'h0959, 1, 0));
        vecs.push_back(mk("pause_0959",  0, 1, 0, 0, 16'h0000, 16'h0959, 0, 0));
        vecs.push_back(mk("pa_st_0959",  0, 1, 1, 0, 16'h0000, 16'h0959, 0, 0));
        vecs.push_back(mk("resume_tick", 0, 0, 1, 1, 16'h0000, 16'h0959, 1, 0));
        vecs.push_back(mk("tick_0958",   0, 0, 0, 1, 16'h0000, 16'h0958, 1, 0));

        #12;
        check("reset", 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].pa, vecs[i].st, vecs[i].tk, vecs[i].pre);
            check(vecs[i].name, vecs[i].exp_val, vecs[i].exp_run, vecs[i].exp_exp);
        end

        // Full borrow chain 10:00 -> 09:59 in one edge, then down to expiry.
        step(1, 0, 0, 0, 16'h1000);
        step(0, 0, 1, 0, 16'h0000);
        step(0, 0, 0, 1, 16'h0000);
        check("chain_0959", 16'h0959, 1'b1, 1'b0);
        for (int n = 0; n < 598; n++) step(0, 0, 0, 1, 16'h0000);
        check("chain_0001", 16'h0001, 1'b1, 1'b0);
        step(0, 0, 0, 1, 16'h0000);
        check("chain_expire", 16'h0000, 1'b0, 1'b1);

        // Pause with coincident tick, idle ticks in PAUSE, then resume.
        step(1, 0, 0, 0, 16'h0130);
        step(0, 0, 1, 0, 16'h0000);
        for (int n = 0; n < 5; n++) step(0, 0, 0, 1, 16'h0000);
        check("pr_0125", 16'h0125, 1'b1, 1'b0);
        step(0, 1, 0, 1, 16'h0000);
        check("pr_pause", 16'h0125, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) step(0, 0, 0, 1, 16'h0000);
        check("pr_hold", 16'h0125, 1'b0, 1'b0);
        step(0, 0, 1, 0, 16'h0000);
        step(0, 0, 0, 1, 16'h0000);
        check("pr_0124", 16'h0124, 1'b1, 1'b0);

        // load + tick + start at 00:01 in RUN: load wins, no expiry.
        step(1, 0, 0, 0, 16'h0001);
        step(0, 0, 1, 0, 16'h0000);
        check("sim_run_0001", 16'h0001, 1'b1, 1'b0);
        step(1, 0, 1, 1, 16'h0200);
        check("sim_load", 16'h0200, 1'b0, 1'b0);

        // Asynchronous reset between edges at 05:17 in RUN.
        step(1, 0, 0, 0, 16'h0517);
        step(0, 0, 1, 0, 16'h0000);
        check("ar_run", 16'h0517, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_async", 16'h0000, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        step(0, 0, 1, 1, 16'h0000);
        check("ar_no_reload", 16'h0000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

MM:SS countdown timer built from four cascaded BCD down-counter digits with a borrow chain, paired with the up-counting BCD stopwatch digits already in the design. The borrow runs from the seconds-units digit towards the minutes-tens digit. A 4-state controller decides when the digits count. The block sits between the 1 Hz prescaler and the 7-segment scan/display logic and flags expiry for the alarm/LED logic.

## Interface
- Parameters: none. Digit width is `BCD_BIT_WIDTH` (4), from `global.v`.
- `clk` in 1: global clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle enable pulse per second, from the prescaler.
- `start` in 1: one-cycle pulse; starts or resumes counting.
- `pause` in 1: one-cycle pulse; freezes counting.
- `load` in 1: one-cycle pulse; copies the preset into the digits.
- `preset_min_t`, `preset_min_u`, `preset_sec_t`, `preset_sec_u` in 4 each: preset digits, BCD.
- `min_t`, `min_u`, `sec_t`, `sec_u` out 4 each: current digits, registered.
- `running` out 1: high while in state RUN.
- `expired` out 1: high while in state EXPIRED.

## Operation
- **States:** IDLE, RUN, PAUSE, EXPIRED.
- **Reset:** state IDLE, all digits `BCD_ZERO`, `running` = 0, `expired` = 0.
- **Input priority in one cycle:** `load` > `pause` > `start` > `tick`.
- **`load` (any state):** digits take the presets, state goes to IDLE, `expired` clears. A coincident `tick` is ignored.
- **`start`:**
  - In IDLE or PAUSE with a nonzero value: go to RUN.
  - With value 00:00: ignored, state unchanged.
  - In RUN or EXPIRED: ignored.
- **`pause`:**
  - In RUN: go to PAUSE, and a coincident `tick` does not decrement.
  - In any other state: ignored.
- **`tick` in RUN:**
  - `sec_u` decrements.
  - A digit at `BCD_ZERO` wraps to its limit and asserts its borrow: `sec_u` 0→9, `sec_t` 0→5, `min_u` 0→9, `min_t` 0→9.
  - Each digit's decrease enable is the borrow of the digit below it. `sec_u`'s enable is `tick` && state==RUN.
- **Expiry:**
  - If a decrement produces 00:00, state goes to EXPIRED on the same edge.
  - Expiry is therefore detected from the current value 00:01 with `tick` present, not one cycle later.
  - RUN never decrements from 00:00, so `min_t` never wraps.
- **EXPIRED:** digits hold 00:00. Only `load` or reset leaves this state.
- **Out-of-range presets** (digit > 9, or `sec_t` > 5): loaded as is. They decrement by 1 each borrow with no clamping until they reach 0, then follow the normal wrap rules.
- `tick` outside RUN has no effect.

## Timing
- All outputs are registered and change only on a `clk` rising edge or on reset assertion.
- Latency: one edge from a sampled `start`/`pause`/`load`/`tick` to the updated outputs.
- The borrow chain is combinational within one cycle. All four digits update on the same edge (for example 10:00 → 09:59 in one edge).
- `running` and `expired` are decoded from the state register and are never both high.
- Reset mid-count returns to IDLE with 00:00 immediately and asynchronously. The preset is not reloaded.

## Structure
- Add to `global.v`:
  - `BCD_FIVE`
  - `DECREMENT`
  - state encodings `STATE_IDLE`, `STATE_RUN`, `STATE_PAUSE`, `STATE_EXPIRED` (2 bits)
- Reuse the existing `BCD_BIT_WIDTH`, `BCD_ZERO`, `BCD_NINE`, `ENABLED` and `DISABLED` from `global.v`.
- Sub-module `dcounter`: one BCD down digit.
  - Ports: `value`, `borrow`, `clk`, `rst_n`, `decrease`, `load_default`, `def_value`, `limit`.
  - `borrow` = `decrease` && `value`==0.
  - `load_default` has priority over `decrease`.
- The top level instantiates four `dcounter`s (limits 9, 5, 9, 9) plus the controller FSM, which contains the 00:01 detect.

## Test plan
- **Reset and basic countdown:** reset, load 00:03, start, 3 ticks → digits step 00:02, 00:01, 00:00. `expired` rises on the third tick edge and `running` falls on the same edge.
- **Full borrow chain:** load 10:00, start, 1 tick → 09:59 in one edge with no intermediate value visible. A further 599 ticks → 00:00 and EXPIRED.
- **Pause/resume:** load 01:30, start, 5 ticks → 01:25. Pause with a coincident tick → still 01:25 in PAUSE. 3 ticks → no change. Start, 1 tick → 01:24.
- **Zero and illegal starts:** start with 00:00 in IDLE → stays IDLE. In EXPIRED, start and tick → stays EXPIRED at 00:00. Load 00:05 → IDLE, `expired` = 0.
- **Simultaneous events:** in RUN at 00:01, assert load (preset 02:00), tick and start together → 02:00, IDLE, `expired` = 0.
- **Async reset mid-run:** at 05:17 in RUN, pulse `rst_n` low between edges → outputs 00:00, `running` = 0 and `expired` = 0 before the next edge.
